program_memory_loader: RTL and testbench
========================================

PROGRAM_MEMORY_LOADER -- requirements
Module: program_memory_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the byte-lane width of one memory location.
REQ-002 Parameter ADD_WIDTH, default 7, SHALL set the address width; depth SHALL be 2**ADD_WIDTH locations.
REQ-003 Parameter INSTR_BYTES, default 4, SHALL set the locations concatenated per fetched instruction.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 load_start  input  1  SHALL request a new program load starting at address 0.
REQ-007 load_valid  input  1  SHALL qualify load_data.
REQ-008 load_data  input  DATA_WIDTH  SHALL carry the byte to be written.
REQ-009 load_last  input  1  SHALL mark the final byte of a load.
REQ-010 load_ready  output  1  SHALL indicate the block accepts a byte this cycle.
REQ-011 load_done  output  1  SHALL indicate a completed load.
REQ-012 load_count  output  ADD_WIDTH+1  SHALL report bytes written in the current or last load.
REQ-013 err_overflow  output  1  SHALL flag a load that filled the memory without load_last.
REQ-014 fetch_req  input  1  SHALL request an instruction fetch.
REQ-015 fetch_addr  input  ADD_WIDTH  SHALL give the byte address of the fetch.
REQ-016 fetch_valid  output  1  SHALL mark instruction valid.
REQ-017 instruction  output  INSTR_BYTES*DATA_WIDTH  SHALL carry the fetched instruction.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, DONE.
REQ-019 IDLE/DONE with load_start=1 SHALL go to LOAD, clear the write pointer and load_count, and clear load_done and err_overflow.
REQ-020 In LOAD, load_ready SHALL be 1; a byte is accepted when load_valid and load_ready are both 1.
REQ-021 An accepted byte SHALL be written to the pointer address, then the pointer and load_count SHALL increment by 1.
REQ-022 An accepted byte with load_last=1 SHALL move LOAD to DONE.
REQ-023 An accepted byte at address 2**ADD_WIDTH-1 with load_last=0 SHALL move to DONE and set err_overflow; the pointer SHALL NOT wrap.
REQ-024 load_start in LOAD SHALL be ignored; load_valid outside LOAD SHALL be ignored and write nothing.
REQ-025 load_done SHALL be 1 exactly while in DONE.
REQ-026 In IDLE/DONE, fetch_req=1 SHALL register instruction one cycle later, with byte lane i (LSB lane 0) = memory[(fetch_addr+i) mod 2**ADD_WIDTH].
REQ-027 fetch_valid SHALL be 1 in the cycle after an accepted fetch_req, else 0.
REQ-028 fetch_req during LOAD, or coincident with an accepted load_start, SHALL be ignored (fetch_valid=0 next cycle).
REQ-029 instruction SHALL hold its value when no fetch is accepted.
REQ-030 Fetch reads SHALL return the contents prior to the write in the same cycle (no write-to-read bypass).

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, pointer 0, load_count 0, load_done 0, err_overflow 0, fetch_valid 0, instruction 0, load_ready 0.
REQ-032 Memory contents SHALL NOT be reset; reset mid-LOAD SHALL abandon the load, retaining bytes already written.

Configuration
REQ-033 Macro PMEM_LOCK_EN: when defined, load_start SHALL be ignored in DONE until the next reset (write-once program); when undefined, load_start in DONE SHALL start a reload per REQ-019.

Verification
REQ-034 Reset, load_start, bytes 0x13,0x00,0x50,0x00 with load_last on 4th -> load_done=1, load_count=4, err_overflow=0.
REQ-035 After REQ-034, fetch_req, fetch_addr=0 -> next cycle fetch_valid=1, instruction=0x00500013.
REQ-036 Default params, 128 bytes without load_last -> DONE, err_overflow=1, load_count=128; fetch_addr=126 returns lanes from addresses 126,127,0,1.
REQ-037 fetch_req and load_start asserted together in DONE (macro undefined) -> LOAD entered, fetch_valid=0 next cycle; with PMEM_LOCK_EN -> stays DONE, fetch_valid=1.
REQ-038 rst_n low after 2 of 4 bytes accepted -> all outputs zero asynchronously; after new load_start, load_count restarts from 0.

Source files
------------

// File: rtl/program_memory_loader.sv
// Byte-wide program memory filled by a streaming load port and read back as multi-byte instructions.
// Optional macro PMEM_LOCK_EN makes the program write-once: load_start is ignored in DONE until reset.
module program_memory_loader #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADD_WIDTH   = 7,
  parameter int unsigned INSTR_BYTES = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              load_start_i,
  input  logic                              load_valid_i,
  input  logic [DATA_WIDTH-1:0]             load_data_i,
  input  logic                              load_last_i,
  output logic                              load_ready_o,
  output logic                              load_done_o,
  output logic [ADD_WIDTH:0]                load_count_o,
  output logic                              err_overflow_o,
  input  logic                              fetch_req_i,
  input  logic [ADD_WIDTH-1:0]              fetch_addr_i,
  output logic                              fetch_valid_o,
  output logic [INSTR_BYTES*DATA_WIDTH-1:0] instruction_o
);

  localparam int unsigned Depth = 2 ** ADD_WIDTH;
  localparam logic [ADD_WIDTH-1:0] LastAddr = {ADD_WIDTH{1'b1}};

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e                            state_q, state_d;
  logic [ADD_WIDTH-1:0]              ptr_q, ptr_d;
  logic [ADD_WIDTH:0]                count_q, count_d;
  logic                              err_q, err_d;
  logic                              fetch_valid_q;
  logic [INSTR_BYTES*DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0]             mem_q [Depth];

  logic start_acc;
  logic fetch_acc;
  logic mem_we;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    start_acc = 1'b0;
    unique case (state_q)
      StIdle: start_acc = load_start_i;
      StLoad: begin
        if (load_valid_i) begin
          mem_we  = 1'b1;
          // Pointer saturates at the top location rather than wrapping onto byte 0.
          ptr_d   = (ptr_q == LastAddr) ? ptr_q : ptr_q + 1'b1;
          count_d = count_q + 1'b1;
          if (load_last_i) begin
            state_d = StDone;
          end else if (ptr_q == LastAddr) begin
            state_d = StDone;
            err_d   = 1'b1;
          end
        end
      end
      StDone: begin
`ifdef PMEM_LOCK_EN
        start_acc = 1'b0;
`else
        start_acc = load_start_i;
`endif
      end
      default: state_d = StIdle;
    endcase
    if (start_acc) begin
      state_d = StLoad;
      ptr_d   = '0;
      count_d = '0;
      err_d   = 1'b0;
    end
  end

  assign fetch_acc = fetch_req_i && (state_q != StLoad) && !start_acc;

  always_comb begin
    instr_d = instr_q;
    if (fetch_acc) begin
      for (int unsigned i = 0; i < INSTR_BYTES; i++) begin
        instr_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[fetch_addr_i + ADD_WIDTH'(i)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      count_q       <= '0;
      err_q         <= 1'b0;
      fetch_valid_q <= 1'b0;
      instr_q       <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      count_q       <= count_d;
      err_q         <= err_d;
      fetch_valid_q <= fetch_acc;
      instr_q       <= instr_d;
    end
  end

  // Storage is deliberately unreset so a reset does not lose a loaded program.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[ptr_q] <= load_data_i;
    end
  end

  assign load_ready_o   = (state_q == StLoad);
  assign load_done_o    = (state_q == StDone);
  assign load_count_o   = count_q;
  assign err_overflow_o = err_q;
  assign fetch_valid_o  = fetch_valid_q;
  assign instruction_o  = instr_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Randomized bench for program_memory_loader against a byte-array model of the program memory.
module tb_program_memory_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic        load_done;
  logic [7:0]  load_count;
  logic        err_overflow;
  logic        fetch_req;
  logic [6:0]  fetch_addr;
  logic        fetch_valid;
  logic [31:0] instruction;

  int total = 0;
  int bad   = 0;
  logic [7:0]  mem_m [128];
  logic [31:0] last_instr;

  always #5 clk = ~clk;

  program_memory_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_start_i   (load_start),
    .load_valid_i   (load_valid),
    .load_data_i    (load_data),
    .load_last_i    (load_last),
    .load_ready_o   (load_ready),
    .load_done_o    (load_done),
    .load_count_o   (load_count),
    .err_overflow_o (err_overflow),
    .fetch_req_i    (fetch_req),
    .fetch_addr_i   (fetch_addr),
    .fetch_valid_o  (fetch_valid),
    .instruction_o  (instruction)
  );

  function automatic logic [31:0] model_instr(input int addr);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = mem_m[(addr + i) % 128];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends n bytes (LOAD state assumed) and updates the model for each accepted byte.
  task automatic send_bytes(input int n, input bit use_last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        load_valid = 1'b0;
        load_data  = 8'($urandom);
        step();
      end
      load_valid = 1'b1;
      load_data  = 8'($urandom);
      load_last  = use_last && (i == n - 1);
      step();
      mem_m[i] = load_data;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic do_load(input int n, input bit use_last, input bit gaps);
`ifdef PMEM_LOCK_EN
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    last_instr = '0;
`endif
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    total++;
    if (load_ready !== 1'b1 || load_count !== 8'd0) begin
      bad++;
      $display("FAIL load_start: ready=%b count=%0d want ready=1 count=0", load_ready, load_count);
    end
    send_bytes(n, use_last, gaps);
  endtask

  task automatic do_fetch(input int addr, input string name);
    logic [31:0] exp;
    exp        = model_instr(addr);
    fetch_req  = 1'b1;
    fetch_addr = 7'(addr);
    step();
    fetch_req  = 1'b0;
    total++;
    if (fetch_valid !== 1'b1 || instruction !== exp) begin
      bad++;
      $display("FAIL %s addr=%0d: valid=%b instr=%h want valid=1 instr=%h",
               name, addr, fetch_valid, instruction, exp);
    end
    last_instr = exp;
    fetch_addr = 7'($urandom);
    step();
    total++;
    if (fetch_valid !== 1'b0 || instruction !== exp) begin
      bad++;
      $display("FAIL %s_hold: valid=%b instr=%h want valid=0 instr=%h",
               name, fetch_valid, instruction, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    load_start = 0; load_valid = 0; load_data = 0; load_last = 0;
    fetch_req = 0; fetch_addr = 0;
    #12;
    rst_n = 1'b1;
    step();
    last_instr = '0;
    total++;
    if ({load_ready, load_done, err_overflow, fetch_valid} !== 4'b0 || load_count !== 8'd0 ||
        instruction !== 32'd0) begin
      bad++;
      $display("FAIL reset: ready=%b done=%b err=%b fv=%b count=%0d instr=%h want all zero",
               load_ready, load_done, err_overflow, fetch_valid, load_count, instruction);
    end
  endtask

  task automatic test_basic();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data  = (i == 0) ? 8'h13 : (i == 2) ? 8'h50 : 8'h00;
      load_last  = (i == 3);
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    mem_m[0] = 8'h13; mem_m[1] = 8'h00; mem_m[2] = 8'h50; mem_m[3] = 8'h00;
    total++;
    if (load_done !== 1'b1 || load_count !== 8'd4 || err_overflow !== 1'b0 || load_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_load: done=%b count=%0d err=%b ready=%b want 1 4 0 0",
               load_done, load_count, err_overflow, load_ready);
    end
    fetch_req  = 1'b1;
    fetch_addr = 7'd0;
    step();
    fetch_req = 1'b0;
    total++;
    if (fetch_valid !== 1'b1 || instruction !== 32'h0050_0013) begin
      bad++;
      $display("FAIL basic_fetch: valid=%b instr=%h want valid=1 instr=00500013",
               fetch_valid, instruction);
    end
    last_instr = 32'h0050_0013;
  endtask

  task automatic test_overflow();
    do_load(128, 1'b0, 1'b1);
    total++;
    if (load_done !== 1'b1 || err_overflow !== 1'b1 || load_count !== 8'd128) begin
      bad++;
      $display("FAIL overflow: done=%b err=%b count=%0d want 1 1 128",
               load_done, err_overflow, load_count);
    end
    do_fetch(126, "fetch_wrap");
    do_load(128, 1'b1, 1'b0);
    total++;
    if (load_done !== 1'b1 || err_overflow !== 1'b0 || load_count !== 8'd128) begin
      bad++;
      $display("FAIL full_with_last: done=%b err=%b count=%0d want 1 0 128",
               load_done, err_overflow, load_count);
    end
    do_fetch(127, "fetch_top");
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(1, 127);
      do_load(n, 1'b1, 1'b1);
      total++;
      if (load_done !== 1'b1 || err_overflow !== 1'b0 || load_count !== 8'(n)) begin
        bad++;
        $display("FAIL rand_load n=%0d: done=%b err=%b count=%0d", n, load_done, err_overflow,
                 load_count);
      end
      for (int j = 0; j < 4; j++) do_fetch($urandom_range(0, 127), "rand_fetch");
    end
  endtask

  task automatic test_fetch_in_load();
    do_load(3, 1'b0, 1'b0);
    fetch_req  = 1'b1;
    fetch_addr = 7'd5;
    step();
    fetch_req = 1'b0;
    total++;
    if (fetch_valid !== 1'b0 || instruction !== last_instr || load_count !== 8'd3) begin
      bad++;
      $display("FAIL fetch_in_load: valid=%b instr=%h count=%0d want valid=0 instr=%h count=3",
               fetch_valid, instruction, load_count, last_instr);
    end
    load_start = 1'b1;
    for (int i = 3; i < 6; i++) begin
      load_valid = 1'b1;
      load_data  = 8'($urandom);
      load_last  = (i == 5);
      step();
      mem_m[i] = load_data;
    end
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    total++;
    if (load_done !== 1'b1 || load_count !== 8'd6) begin
      bad++;
      $display("FAIL start_in_load: done=%b count=%0d want done=1 count=6", load_done, load_count);
    end
    do_fetch(2, "fetch_after_load");
  endtask

  task automatic test_done_ignores_valid();
    logic [7:0] cnt;
    cnt = load_count;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = ~mem_m[0];
      load_last  = 1'b1;
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    total++;
    if (load_done !== 1'b1 || load_count !== cnt) begin
      bad++;
      $display("FAIL done_valid: done=%b count=%0d want done=1 count=%0d", load_done, load_count, cnt);
    end
    do_fetch(0, "done_no_write");
  endtask

  task automatic test_collision();
    logic [31:0] exp;
    exp        = model_instr(9);
    fetch_req  = 1'b1;
    fetch_addr = 7'd9;
    load_start = 1'b1;
    step();
    fetch_req  = 1'b0;
    load_start = 1'b0;
`ifdef PMEM_LOCK_EN
    total++;
    if (load_done !== 1'b1 || fetch_valid !== 1'b1 || instruction !== exp) begin
      bad++;
      $display("FAIL collision_lock: done=%b valid=%b instr=%h want done=1 valid=1 instr=%h",
               load_done, fetch_valid, instruction, exp);
    end
    last_instr = exp;
`else
    total++;
    if (load_ready !== 1'b1 || fetch_valid !== 1'b0 || instruction !== last_instr) begin
      bad++;
      $display("FAIL collision: ready=%b valid=%b instr=%h want ready=1 valid=0 instr=%h",
               load_ready, fetch_valid, instruction, last_instr);
    end
    send_bytes(4, 1'b1, 1'b0);
`endif
    do_fetch(1, "after_collision");
  endtask

  task automatic test_reset_mid_load();
    do_load(2, 1'b0, 1'b0);
    load_valid = 1'b1;
    load_data  = ~mem_m[2];
    rst_n = 1'b0;
    #1;
    total++;
    if ({load_ready, load_done, err_overflow, fetch_valid} !== 4'b0 || load_count !== 8'd0 ||
        instruction !== 32'd0) begin
      bad++;
      $display("FAIL async_reset: ready=%b done=%b err=%b fv=%b count=%0d instr=%h want all zero",
               load_ready, load_done, err_overflow, fetch_valid, load_count, instruction);
    end
    last_instr = '0;
    load_valid = 1'b0;
    #13;
    rst_n = 1'b1;
    step();
    do_fetch(0, "reset_retain");
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    total++;
    if (load_count !== 8'd0 || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL restart: count=%0d ready=%b want count=0 ready=1", load_count, load_ready);
    end
    send_bytes(1, 1'b1, 1'b0);
    total++;
    if (load_count !== 8'd1 || load_done !== 1'b1) begin
      bad++;
      $display("FAIL restart_count: count=%0d done=%b want count=1 done=1", load_count, load_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_random();
    test_fetch_in_load();
    test_done_ignores_valid();
    test_collision();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
